// File: rtl/bpu_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_reg_pkg
// Description : Shared types and limits for the register file and its cells.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_reg_pkg;

    typedef enum logic [1:0] {
        CNT_NONE = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_t;

    localparam int REG_DEPTH_MAX = 16;

endpackage
`default_nettype wire

// File: rtl/reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : reg_cell
// Description : Single WIDTH-bit register with sync reset, load and inc/dec.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cell
    import bpu_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  cnt_op_t          op,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_data;
        end else begin
            case (op)
                CNT_INC: r_value <= r_value + WIDTH'(1);
                CNT_DEC: r_value <= r_value - WIDTH'(1);
                default: r_value <= r_value;
            endcase
        end
    end

    // Wrap is only meaningful when the counter operation actually applies.
    assign wrap  = !load && (((op == CNT_INC) && (&r_value)) ||
                             ((op == CNT_DEC) && (~|r_value)));
    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : DEPTH x WIDTH register file, one write port, two read ports,
//               and an in-place inc/dec counter port with registered carry.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import bpu_reg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  data_out_a,
    input  logic              read_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  data_out_b,
    input  logic              inc,
    input  logic              dec,
    input  logic [ADDR_W-1:0] caddr,
    output logic              carry
);

    logic              w_wvalid;
    logic              w_cvalid;
    cnt_op_t           w_op;
    logic [WIDTH-1:0]  w_regs [DEPTH];
    logic [DEPTH-1:0]  w_wrap;
    logic              r_carry;

    assign w_wvalid = write && (32'(waddr) < DEPTH);

    // Simultaneous inc+dec cancels; a write to the same address wins.
    assign w_cvalid = (inc ^ dec) && (32'(caddr) < DEPTH) &&
                      !(w_wvalid && (waddr == caddr));

    always_comb begin
        w_op = CNT_NONE;
        if (w_cvalid) begin
            w_op = inc ? CNT_INC : CNT_DEC;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cells
        reg_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .load     (w_wvalid && (waddr == ADDR_W'(i))),
            .load_data(data_in),
            .op       ((caddr == ADDR_W'(i)) ? w_op : CNT_NONE),
            .value    (w_regs[i]),
            .wrap     (w_wrap[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= |w_wrap;
        end
    end

    assign carry = r_carry;

    // Out-of-range or disabled reads fall through to zero.
    always_comb begin
        data_out_a = '0;
        data_out_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_a && (raddr_a == ADDR_W'(i))) data_out_a = w_regs[i];
            if (read_b && (raddr_b == ADDR_W'(i))) data_out_b = w_regs[i];
        end
    end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each register.
REQ-002 Parameter DEPTH, default 4, number of registers; legal range 2..16.
REQ-003 Localparam ADDR_W, value $clog2(DEPTH), address width of all address ports.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 write  in  1  write strobe for the write port.
REQ-007 waddr  in  ADDR_W  write address.
REQ-008 data_in  in  WIDTH  write data.
REQ-009 read_a  in  1  enable for read port A.
REQ-010 raddr_a  in  ADDR_W  read address for port A.
REQ-011 data_out_a  out  WIDTH  read data for port A.
REQ-012 read_b  in  1  enable for read port B.
REQ-013 raddr_b  in  ADDR_W  read address for port B.
REQ-014 data_out_b  out  WIDTH  read data for port B.
REQ-015 inc  in  1  increment strobe for the register at caddr.
REQ-016 dec  in  1  decrement strobe for the register at caddr.
REQ-017 caddr  in  ADDR_W  counter-operation address.
REQ-018 carry  out  1  registered wrap flag for the previous inc or dec.

Function
REQ-019 write=1 with waddr<DEPTH SHALL load data_in into register waddr at the next rising edge.
REQ-020 Read ports SHALL be combinational from stored contents; no write-to-read bypass, so a same-cycle write becomes visible the cycle after.
REQ-021 data_out_x SHALL be 0 when read_x=0 or raddr_x>=DEPTH, giving bus-safe idle outputs.
REQ-022 Both read ports SHALL operate independently and may address the same register.
REQ-023 inc=1, dec=0 SHALL set register caddr to its value +1, modulo 2^WIDTH.
REQ-024 dec=1, inc=0 SHALL set register caddr to its value -1, modulo 2^WIDTH.
REQ-025 inc=1 and dec=1 together SHALL be a no-op on the register and SHALL clear carry.
REQ-026 carry SHALL be 1 for exactly the cycle after an effective inc from all-ones or dec from 0; otherwise 0.
REQ-027 write and inc/dec to the same address in one cycle SHALL resolve as: the write wins, the counter operation is dropped, and carry is 0.
REQ-028 write and inc/dec to different addresses in one cycle SHALL both take effect.
REQ-029 Any write, waddr, or caddr >= DEPTH SHALL be ignored, and carry SHALL be 0.
REQ-030 Latency SHALL be one cycle for write, inc, dec, and carry, and zero cycles for reads.

Reset
REQ-031 rst=1 at a rising edge SHALL clear every register and carry to 0, overriding write, inc, and dec in that cycle.
REQ-032 Read ports SHALL remain functional during reset and return 0 for enabled, in-range reads once reset has taken effect.
REQ-033 Reset asserted mid-sequence, such as between consecutive inc strobes, SHALL discard all prior state with no residual carry.

Structure
REQ-034 Shared package bpu_reg_pkg SHALL hold the typedef cnt_op_t {CNT_NONE, CNT_INC, CNT_DEC} and the DEPTH limit constant REG_DEPTH_MAX=16.
REQ-035 One sub-module, reg_cell, SHALL implement a single WIDTH-bit register with sync reset, load, and inc/dec, and SHALL emit a wrap output.
REQ-036 register_file SHALL instantiate DEPTH reg_cell instances and SHALL contain the address decode, read muxes, and carry register.

Verification
REQ-037 Reset, write 0xA5 to reg 1, read_a=1 raddr_a=1 next cycle -> data_out_a=0xA5; read_a=0 -> data_out_a=0x00.
REQ-038 Write 0xFF to reg 2, inc at caddr=2 -> reg 2=0x00 and carry=1 for exactly one cycle; second inc -> 0x01 and carry=0.
REQ-039 Reg 3=0x00, dec -> 0xFF with carry=1; inc and dec together on reg 3 -> stays 0xFF with carry=0.
REQ-040 Same cycle: write 0x10 to reg 0 and inc on reg 0 -> reg 0=0x10; write reg 0 and inc reg 1 (0x07) -> 0x10 and 0x08.
REQ-041 Same cycle: write 0x3C to reg 1 with read_a on reg 1 -> old value that cycle, 0x3C the next; port B reads reg 1 concurrently with an identical result.
REQ-042 Load all registers, then assert rst together with write and inc -> all registers 0, carry 0; DEPTH=3 variant: address 3 write ignored and read returns 0.
